pipeline_event_monitor: RTL

Cycle-accurate event monitor for the 5-stage MIPS CPU. It sits beside the CPU top and consumes the per-cycle hazard signals: ID-stage stall, IF/ID flush on branch/jump, and WB retire. It produces cycle, stall, flush and retire counts plus a run-limit done flag. The testbench reads these counters and the done flag instead of counting events itself.

---
 rtl/pipeline_event_monitor.sv | 121 ++++++++++++
 1 files changed

// File: rtl/pipeline_event_monitor.sv
// Cycle/stall/flush/retire event monitor for the 5-stage MIPS pipeline.
// Registered outputs only; counters saturate; run-limit moves the monitor into a frozen DONE state.
module pipeline_event_monitor #(
  parameter int CNT_W       = 32,
  parameter int CYCLE_LIMIT = 30
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             retire_i,
  input  logic             clear_i,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] retire_cnt_o,
  output logic             running_o,
  output logic             done_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // A limit wider than the counter can never be reached, so it disables the limit.
  localparam logic [63:0]      LIM_64  = 64'(CYCLE_LIMIT);
  localparam logic [63:0]      CNT_MAX = (64'd1 << CNT_W) - 64'd1;
  localparam bit               LIM_EN  = (CYCLE_LIMIT != 0) && (LIM_64 <= CNT_MAX);
  localparam logic [CNT_W-1:0] LIM_CNT = LIM_64[CNT_W-1:0];
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [CNT_W-1:0] r_retire_cnt;
  logic             r_running;
  logic             r_done;

  logic [CNT_W-1:0] w_cycle_nxt;
  logic [CNT_W-1:0] w_stall_nxt;
  logic [CNT_W-1:0] w_flush_nxt;
  logic [CNT_W-1:0] w_retire_nxt;
  logic             w_limit_hit;

  assign w_cycle_nxt  = (&r_cycle_cnt)  ? r_cycle_cnt  : r_cycle_cnt  + ONE;
  assign w_stall_nxt  = (&r_stall_cnt)  ? r_stall_cnt  : r_stall_cnt  + ONE;
  assign w_flush_nxt  = (&r_flush_cnt)  ? r_flush_cnt  : r_flush_cnt  + ONE;
  assign w_retire_nxt = (&r_retire_cnt) ? r_retire_cnt : r_retire_cnt + ONE;
  assign w_limit_hit  = LIM_EN && (w_cycle_nxt == LIM_CNT);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_cycle_cnt  <= '0;
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
      r_retire_cnt <= '0;
      r_running    <= 1'b0;
      r_done       <= 1'b0;
    end else if (clear_i) begin
      r_state      <= S_IDLE;
      r_cycle_cnt  <= '0;
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
      r_retire_cnt <= '0;
      r_running    <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_state   <= S_RUN;
            r_running <= 1'b1;
          end
        end
        S_RUN: begin
          if (!start_i) begin
            r_state   <= S_IDLE;
            r_running <= 1'b0;
          end else begin
            r_cycle_cnt <= w_cycle_nxt;
            // A cycle that both flushes and stalls is accounted as a flush only.
            if (flush_i) begin
              r_flush_cnt <= w_flush_nxt;
            end else if (stall_i) begin
              r_stall_cnt <= w_stall_nxt;
            end
            if (retire_i) begin
              r_retire_cnt <= w_retire_nxt;
            end
            if (w_limit_hit) begin
              r_state   <= S_DONE;
              r_running <= 1'b0;
              r_done    <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_DONE;
        end
        default: begin
          r_state   <= S_IDLE;
          r_running <= 1'b0;
          r_done    <= 1'b0;
        end
      endcase
    end
  end

  assign cycle_cnt_o  = r_cycle_cnt;
  assign stall_cnt_o  = r_stall_cnt;
  assign flush_cnt_o  = r_flush_cnt;
  assign retire_cnt_o = r_retire_cnt;
  assign running_o    = r_running;
  assign done_o       = r_done;

endmodule
